// File: rtl/ascon_block_packer.sv
// Packs a valid/ready byte stream (associated data, then message data) into
// ASCON rate blocks with 0x80 padding and hands them to the core one at a time.
module ascon_block_packer #(
    parameter int RATE_BYTES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    ad_present_i,
    input  logic [7:0]              byte_i,
    input  logic                    byte_valid_i,
    output logic                    byte_ready_o,
    input  logic                    byte_last_i,
    input  logic                    byte_empty_i,
    input  logic                    byte_is_ad_i,
    output logic [RATE_BYTES*8-1:0] block_o,
    output logic                    block_valid_o,
    input  logic                    block_ready_i,
    output logic                    block_is_ad_o,
    output logic                    block_last_o,
    output logic [3:0]              block_nbytes_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o
);

    // state     | meaning
    // IDLE      | waiting for start_i
    // AD_FILL   | collecting associated-data bytes
    // AD_EMIT   | offering an associated-data block to the core
    // DATA_FILL | collecting message bytes
    // DATA_EMIT | offering a message block to the core
    // PAD_EMIT  | offering the pad-only block after a full final block
    // DONE      | one-cycle completion pulse

    localparam int BW = RATE_BYTES * 8;
    localparam logic [3:0]    LAST_IDX  = 4'(RATE_BYTES - 1);
    localparam logic [BW-1:0] PAD_BLOCK = {8'h80, {(BW-8){1'b0}}};

    typedef enum logic [2:0] {
        IDLE, AD_FILL, AD_EMIT, DATA_FILL, DATA_EMIT, PAD_EMIT, DONE
    } state_t;

    state_t        state, state_next;
    logic [BW-1:0] shift_buf, buf_fill, byte_sh, pad_sh;
    logic [3:0]    cnt, n_next, nbytes_r;
    logic          last_r, pad_pend, pad_ad, error_r;
    logic          fill, beat, phase_err, take, full, close, handshake;

    assign fill      = (state == AD_FILL) || (state == DATA_FILL);
    assign beat      = fill && byte_valid_i;
    assign phase_err = beat && ((byte_is_ad_i != (state == AD_FILL)) ||
                                (byte_empty_i && !byte_last_i));
    assign take      = beat && !phase_err;
    assign full      = !byte_empty_i && (cnt == LAST_IDX);
    assign close     = take && (full || byte_last_i);
    assign handshake = block_valid_o && block_ready_i;

    // An empty beat adds no byte, so the pad lands right after the bytes already held.
    always_comb begin
        byte_sh  = {byte_i, {(BW-8){1'b0}}} >> {cnt, 3'b000};
        n_next   = byte_empty_i ? cnt : cnt + 4'd1;
        pad_sh   = PAD_BLOCK >> {n_next, 3'b000};
        buf_fill = byte_empty_i ? shift_buf : (shift_buf | byte_sh);
        if (byte_last_i && !full)
            buf_fill = buf_fill | pad_sh;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next    = state;
        byte_ready_o  = 1'b0;
        block_valid_o = 1'b0;
        block_is_ad_o = 1'b0;
        busy_o        = 1'b1;
        done_o        = 1'b0;
        case (state)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i)
                    state_next = ad_present_i ? AD_FILL : DATA_FILL;
            end
            AD_FILL: begin
                byte_ready_o = 1'b1;
                if (close)
                    state_next = AD_EMIT;
            end
            DATA_FILL: begin
                byte_ready_o = 1'b1;
                if (close)
                    state_next = DATA_EMIT;
            end
            AD_EMIT: begin
                block_valid_o = 1'b1;
                block_is_ad_o = 1'b1;
                if (block_ready_i)
                    state_next = pad_pend ? PAD_EMIT : (last_r ? DATA_FILL : AD_FILL);
            end
            DATA_EMIT: begin
                block_valid_o = 1'b1;
                if (block_ready_i)
                    state_next = pad_pend ? PAD_EMIT : (last_r ? DONE : DATA_FILL);
            end
            PAD_EMIT: begin
                block_valid_o = 1'b1;
                block_is_ad_o = pad_ad;
                if (block_ready_i)
                    state_next = pad_ad ? DATA_FILL : DONE;
            end
            DONE: begin
                busy_o     = 1'b0;
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shift_buf <= '0;
            cnt       <= '0;
            nbytes_r  <= '0;
            last_r    <= 1'b0;
            pad_pend  <= 1'b0;
            pad_ad    <= 1'b0;
            error_r   <= 1'b0;
        end else begin
            if (state == IDLE && start_i) begin
                shift_buf <= '0;
                cnt       <= '0;
                nbytes_r  <= '0;
                last_r    <= 1'b0;
                pad_pend  <= 1'b0;
                error_r   <= 1'b0;
            end
            if (phase_err)
                error_r <= 1'b1;
            if (take) begin
                shift_buf <= buf_fill;
                cnt       <= n_next;
                if (close) begin
                    nbytes_r <= n_next;
                    last_r   <= !full;
                    pad_pend <= full && byte_last_i;
                    pad_ad   <= (state == AD_FILL);
                end
            end
            // A full final block still owes the segment its pad-only block.
            if (handshake) begin
                cnt <= '0;
                if (pad_pend) begin
                    shift_buf <= PAD_BLOCK;
                    nbytes_r  <= '0;
                    last_r    <= 1'b1;
                    pad_pend  <= 1'b0;
                end else begin
                    shift_buf <= '0;
                    nbytes_r  <= '0;
                    last_r    <= 1'b0;
                end
            end
        end
    end

    assign block_o        = shift_buf;
    assign block_nbytes_o = nbytes_r;
    assign block_last_o   = last_r;
    assign error_o        = error_r;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Randomized bench for ascon_block_packer: a chunk-and-pad reference model
// predicts every block; a monitor checks handshakes, hold stability and done_o.
module tb_ascon_block_packer;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        ad_present_i = 1'b0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        byte_last_i = 1'b0;
    logic        byte_empty_i = 1'b0;
    logic        byte_is_ad_i = 1'b0;
    logic [63:0] block_o;
    logic        block_valid_o;
    logic        block_ready_i = 1'b0;
    logic        block_is_ad_o;
    logic        block_last_o;
    logic [3:0]  block_nbytes_o;
    logic        busy_o;
    logic        done_o;
    logic        error_o;

    ascon_block_packer #(.RATE_BYTES(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .ad_present_i(ad_present_i),
        .byte_i(byte_i), .byte_valid_i(byte_valid_i), .byte_ready_o(byte_ready_o),
        .byte_last_i(byte_last_i), .byte_empty_i(byte_empty_i), .byte_is_ad_i(byte_is_ad_i),
        .block_o(block_o), .block_valid_o(block_valid_o), .block_ready_i(block_ready_i),
        .block_is_ad_o(block_is_ad_o), .block_last_o(block_last_o),
        .block_nbytes_o(block_nbytes_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    endtask

    // Expected block entries: {block, nbytes, is_ad, last}.
    logic [69:0] exp_q[$];
    logic [7:0]  ad_q[$];
    logic [7:0]  dt_q[$];
    bit          rdy_low = 1'b0;
    bit          inject_en = 1'b0;
    bit          had_err;
    bit          exp_done = 1'b0;
    bit          held_v = 1'b0;
    logic [69:0] held;
    int          n_done = 0;

    task automatic model_segment(input bit is_ad);
        logic [7:0]  q[$];
        logic [63:0] blk;
        int          i, rem;
        if (is_ad) q = ad_q; else q = dt_q;
        i = 0;
        while (q.size() - i >= 8) begin
            blk = '0;
            for (int k = 0; k < 8; k++) blk[63-8*k -: 8] = q[i+k];
            exp_q.push_back({blk, 4'd8, is_ad, 1'b0});
            i += 8;
        end
        rem = q.size() - i;
        blk = '0;
        for (int k = 0; k < rem; k++) blk[63-8*k -: 8] = q[i+k];
        blk[63-8*rem -: 8] = 8'h80;
        exp_q.push_back({blk, 4'(rem), is_ad, 1'b1});
    endtask

    always @(posedge clk_i) begin
        #1;
        block_ready_i = rdy_low ? 1'b0 : ($urandom_range(0, 9) < 7);
    end

    always @(negedge clk_i) begin
        logic [69:0] cur, e;
        if (!rst_i) begin
            check("done", done_o, exp_done);
            exp_done = 1'b0;
            if (done_o) n_done++;
            if (block_valid_o) begin
                check("byte_ready_in_emit", byte_ready_o, 0);
                cur = {block_o, block_nbytes_o, block_is_ad_o, block_last_o};
                if (held_v) check("block_hold", cur, held);
                if (block_ready_i) begin
                    check("block_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("block", cur, e);
                        if (e[1:0] == 2'b01) exp_done = 1'b1;
                    end
                    held_v = 1'b0;
                end else begin
                    held   = cur;
                    held_v = 1'b1;
                end
            end else begin
                held_v = 1'b0;
            end
        end
    end

    // Entered and left at 1 time unit after a rising edge.
    task automatic send_beat(input logic [7:0] b, input bit last, input bit empty, input bit is_ad);
        byte_i = b; byte_last_i = last; byte_empty_i = empty; byte_is_ad_i = is_ad;
        byte_valid_i = 1'b1;
        for (int t = 0; ; t++) begin
            @(negedge clk_i);
            if (byte_ready_o) break;
            if (t > 1000) begin
                check("beat_timeout", 0, 1);
                $fatal(1, "beat never accepted");
            end
        end
        @(posedge clk_i); #1;
        byte_valid_i = 1'b0;
        if ($urandom_range(0, 3) == 0) begin @(posedge clk_i); #1; end
    endtask

    task automatic do_start(input bit ad_p);
        start_i = 1'b1; ad_present_i = ad_p;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        @(negedge clk_i);
        check("busy_after_start", busy_o, 1);
        check("ready_after_start", byte_ready_o, 1);
        check("error_cleared", error_o, 0);
        @(posedge clk_i); #1;
    endtask

    task automatic send_segment(input bit is_ad);
        logic [7:0] q[$];
        int r;
        if (is_ad) q = ad_q; else q = dt_q;
        if (q.size() == 0) begin
            send_beat(8'h00, 1'b1, 1'b1, is_ad);
            return;
        end
        for (int i = 0; i < q.size(); i++) begin
            r = $urandom_range(0, 9);
            if (inject_en && r == 0) begin
                send_beat(8'hAA, 1'b0, 1'b0, !is_ad);
                had_err = 1'b1;
            end else if (inject_en && r == 1) begin
                send_beat(8'($urandom), 1'b0, 1'b1, is_ad);
                had_err = 1'b1;
            end
            if (!is_ad && i < q.size() - 1 && $urandom_range(0, 5) == 0) begin
                start_i = 1'b1; ad_present_i = 1'b1;
                @(posedge clk_i); #1;
                start_i = 1'b0;
            end
            send_beat(q[i], i == q.size() - 1, 1'b0, is_ad);
        end
    endtask

    task automatic send_msg(input bit ad_p);
        int prev;
        prev    = n_done;
        had_err = 1'b0;
        if (ad_p) model_segment(1'b1);
        model_segment(1'b0);
        do_start(ad_p);
        if (ad_p) send_segment(1'b1);
        send_segment(1'b0);
        for (int t = 0; ; t++) begin
            @(negedge clk_i);
            if (n_done > prev) break;
            if (t > 5000) begin
                check("done_timeout", 0, 1);
                $fatal(1, "done_o never seen");
            end
        end
        @(posedge clk_i); #1;
        check("error_sticky", error_o, had_err);
        check("busy_idle", busy_o, 0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        #1;
        check("reset_outputs", {block_o, block_nbytes_o, block_is_ad_o, block_last_o, block_valid_o,
                                byte_ready_o, busy_o, done_o, error_o}, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("idle_outputs", {block_o, block_nbytes_o, block_is_ad_o, block_last_o, block_valid_o,
                               byte_ready_o, busy_o, done_o, error_o}, 0);
        @(posedge clk_i); #1;

        ad_q = '{8'h01, 8'h02, 8'h03};
        dt_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
        send_msg(1'b1);
        ad_q.delete(); dt_q.delete();
        send_msg(1'b0);

        // Stall a block, then reset while it is offered.
        rdy_low = 1'b1;
        do_start(1'b0);
        dt_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        for (int i = 0; i < 5; i++) send_beat(dt_q[i], i == 4, 1'b0, 1'b0);
        repeat (5) @(negedge clk_i);
        check("stalled_valid", block_valid_o, 1);
        check("stalled_block", {block_o, block_nbytes_o, block_last_o}, {64'h1122334455800000, 4'd5, 1'b1});
        #2 rst_i = 1'b1;
        #1;
        check("mid_reset_outputs", {block_o, block_nbytes_o, block_is_ad_o, block_last_o, block_valid_o,
                                    byte_ready_o, busy_o, done_o, error_o}, 0);
        exp_q.delete(); held_v = 1'b0; exp_done = 1'b0;
        @(posedge clk_i); #1;
        rst_i = 1'b0; rdy_low = 1'b0;

        inject_en = 1'b1;
        for (int m = 0; m < 40; m++) begin
            int len;
            bit ad_p;
            ad_p = 1'($urandom);
            ad_q.delete(); dt_q.delete();
            if (ad_p) begin
                len = ($urandom_range(0, 3) == 0) ? 8 * $urandom_range(0, 2) : $urandom_range(0, 19);
                for (int i = 0; i < len; i++) ad_q.push_back(8'($urandom));
            end
            len = ($urandom_range(0, 3) == 0) ? 8 * $urandom_range(0, 2) : $urandom_range(0, 20);
            for (int i = 0; i < len; i++) dt_q.push_back(8'($urandom));
            send_msg(ad_p);
        end

        check("no_leftover_blocks", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ascon_block_packer.md
# ascon_block_packer

Byte-stream front end that feeds the ASCON cipher core. Accepts associated data and then plaintext or ciphertext as a valid/ready byte stream. Packs the bytes into 64-bit rate blocks with ASCON padding and hands each block to the core over a valid/ready block interface. Sits between the host interface and the cipher core's data and associated-data input registers.

## Interface
- RATE_BYTES, 8, bytes per rate block; block width = RATE_BYTES*8
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  begin a message; sampled only in IDLE
- ad_present_i  in  1  sampled with start_i; 0 = no associated data phase
- byte_i  in  8  stream byte
- byte_valid_i  in  1  stream beat valid
- byte_ready_o  out  1  packer accepts a beat this cycle
- byte_last_i  in  1  beat is the last of the current segment (AD or data)
- byte_empty_i  in  1  beat carries no byte; legal only with byte_last_i=1 (zero-length segment)
- byte_is_ad_i  in  1  beat belongs to associated data
- block_o  out  RATE_BYTES*8  packed, padded block; first byte in the MSBs
- block_valid_o  out  1  block_o valid
- block_ready_i  in  1  core accepts the block
- block_is_ad_o  out  1  block is associated data
- block_last_o  out  1  final block of its segment
- block_nbytes_o  out  4  real (unpadded) bytes in the block, 0..RATE_BYTES
- busy_o  out  1  high from start accept until done
- done_o  out  1  one-cycle pulse when the final data block handshakes
- error_o  out  1  sticky phase error; cleared by the next accepted start_i

## Operation
- States: IDLE, AD_FILL, AD_EMIT, DATA_FILL, DATA_EMIT, PAD_EMIT, DONE.
- IDLE: start_i=1 → AD_FILL if ad_present_i=1, otherwise DATA_FILL. The byte count and the shift buffer clear.
- FILL: byte_ready_o=1. Each beat is accepted when byte_valid_i=1. Byte k of the block is placed at bits [8*(RATE_BYTES-k)-1 -: 8].
- FILL → EMIT when the RATE_BYTES-th byte is accepted or byte_last_i=1.
- Padding on the last block of a segment with n<RATE_BYTES real bytes: byte n = 0x80, remaining bytes 0x00, block_nbytes_o=n, block_last_o=1.
- Last beat completing a full block (n=RATE_BYTES): that block goes out with block_last_o=0. After its handshake, PAD_EMIT sends 0x80 followed by zeros, nbytes=0, last=1.
- byte_empty_i beat: treated as n=0 → block 0x8000…00, nbytes=0, last=1.
- EMIT: block_valid_o=1 and byte_ready_o=0. block_o, block_is_ad_o, block_last_o and block_nbytes_o are held constant until block_ready_i=1.
- After the handshake:
  - non-last block → back to the same FILL state;
  - last AD block → DATA_FILL;
  - last data block → DONE.
- PAD_EMIT: block_is_ad_o follows the segment being padded. After its handshake, same transitions as a last block.
- DONE: done_o=1 for one cycle, busy_o=0 → IDLE.
- Phase error: beat with byte_is_ad_i≠(state is AD_FILL). The beat is consumed and dropped, error_o=1, state unchanged.
- start_i outside IDLE is ignored.
- byte_empty_i=1 with byte_last_i=0 counts as a phase error.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE. All outputs 0: byte_ready_o, block_o, block_valid_o, block_is_ad_o, block_last_o, block_nbytes_o, busy_o, done_o, error_o. Buffer and count cleared.
- start_i accepted at cycle S → busy_o=1 and byte_ready_o=1 at S+1.
- Completing beat accepted at cycle N → block_valid_o=1 at N+1. Zero-bubble capture; no double buffering.
- Block handshake at cycle M → byte_ready_o=1 (or pad/next-phase block_valid_o=1) at M+1.
- Final data handshake at M → done_o=1 at M+1, byte_ready_o=0. start_i accepted from M+2.
- Throughput: at most RATE_BYTES bytes per RATE_BYTES+1 cycles with block_ready_i tied high.
- Reset asserted mid-block: partial block discarded, block_valid_o drops immediately; no done_o.

## Test plan
- ad_present_i=1, AD 01 02 03 (last), data 00..07 (last 07) → AD block 0x0102038000000000 (nbytes 3, last, is_ad 1), data 0x0001020304050607 (nbytes 8, last 0), pad 0x8000000000000000 (nbytes 0, last 1), done_o one cycle later.
- ad_present_i=0, single empty last data beat → one block 0x8000000000000000, is_ad 0, nbytes 0, last 1; no AD blocks; done_o.
- Data 11 22 33 44 55 (last), block_ready_i low for 5 cycles → block_o=0x1122334455800000 stable throughout, byte_ready_o=0, accepted on the 6th cycle.
- In AD_FILL, beat byte_is_ad_i=0 value AA → error_o=1 and stays high; next AD block excludes AA; error_o clears on the next start_i.
- rst_i asserted while block_valid_o=1 → all outputs 0 in the same cycle. After release, a new start produces correct blocks with no residue from the old buffer.
- start_i pulsed during DATA_FILL → ignored; block sequence and done_o unchanged.
